exu_mc: RTL and testbench
=========================

EXU_MC -- requirements
Module: exu_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width in bits (legal values 32 and 64).
REQ-002 Parameter RST_PC, default 32'h8000_0000 zero-extended to XLEN, reset value of dnpc.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  issue-side request valid.
REQ-006 in_ready  out  1  unit can accept a request this cycle.
REQ-007 op  in  exu_op_e  operation select.
REQ-008 pc  in  XLEN  PC of the issuing instruction.
REQ-009 src1, src2  in  XLEN each  operands.
REQ-010 jump_flag  in  1  jump instruction: target = src1+src2, link = pc+4.
REQ-011 reg_wen_in  in  1  instruction writes rd.
REQ-012 flush  in  1  kill in-flight operation and pending result.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 reg_wdata  out  XLEN  result; reg_wen  out  1  registered reg_wen_in; dnpc  out  XLEN  next PC.

Function
REQ-016 The ops SHALL be ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU (single-cycle class) and MUL, MULHU, DIV, DIVU, REM, REMU (iterative class).
REQ-017 Shift amount SHALL be src2[log2(XLEN)-1:0]; all arithmetic SHALL wrap modulo 2^XLEN.
REQ-018 With jump_flag=1: dnpc = src1+src2 with bit 0 cleared, reg_wdata = pc+4, op ignored; otherwise dnpc = pc+4.
REQ-019 FSM states IDLE, CALC, DONE; in_ready = (state==IDLE) and not flush.
REQ-020 A request is accepted when in_valid and in_ready are both high; single-cycle class or jump: IDLE->DONE, out_valid high on the next cycle (latency 1).
REQ-021 Iterative class: IDLE->CALC; a counter SHALL run XLEN iterations (shift-add multiply, restoring divide on magnitudes), then CALC->DONE; out_valid asserts exactly XLEN+1 cycles after acceptance.
REQ-022 In DONE, out_valid, reg_wdata, reg_wen and dnpc SHALL hold stable until out_ready is high; DONE->IDLE on out_valid and out_ready; no new request is accepted in that same cycle.
REQ-023 Division by zero: DIVU/DIV -> all ones, REMU/REM -> src1, with XLEN-cycle latency unchanged.
REQ-024 Signed overflow (src1 = most negative, src2 = -1): DIV -> src1, REM -> 0.
REQ-025 Signed DIV/REM: quotient negated when operand signs differ; remainder takes the sign of src1.
REQ-026 flush SHALL return the FSM to IDLE on the next edge from any state, drop any result, and deassert out_valid; flush has priority over acceptance and over an out_ready handshake.
REQ-027 MULHU SHALL return the upper XLEN bits of the unsigned 2*XLEN product; MUL returns the lower XLEN bits.

Reset
REQ-028 While rst is high: state=IDLE, counter=0, out_valid=0, reg_wen=0, reg_wdata=0, dnpc=RST_PC, and in_ready=0.
REQ-029 Reset asserted mid-CALC SHALL abandon the operation with no result ever emitted; in_ready rises on the first edge after rst falls.

Structure
REQ-030 exu_op_e, the FSM state enum and XLEN-derived constants SHALL reside in the shared core package.
REQ-031 The iterative multiply/divide datapath SHALL be a sub-module exu_mdu_iter, with start/done handshake, owned by exu_mc; the single-cycle ALU stays inline.

Verification
REQ-032 ADD src1=5, src2=7, out_ready=1 -> out_valid one cycle later, reg_wdata=12, dnpc=pc+4.
REQ-033 jump_flag=1, pc=0x8000_0010, src1=0x8000_0100, src2=0x5 -> dnpc=0x8000_0104, reg_wdata=0x8000_0014.
REQ-034 DIVU 100/7 with XLEN=32 -> out_valid at cycle 33 after accept, reg_wdata=14; REMU gives 2; in_ready=0 throughout.
REQ-035 DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0; DIVU x/0 -> 0xFFFF_FFFF.
REQ-036 MUL result held with out_ready=0 for 5 cycles -> outputs stable; out_ready=1 -> IDLE next cycle.
REQ-037 flush pulse at cycle 10 of a MULHU -> out_valid never asserts, in_ready=1 next cycle; rst mid-CALC -> same, dnpc=RST_PC.

Source files
------------

// File: rtl/exu_mc_pkg.sv
// ============================================================================
// Module      : exu_mc_pkg
// Description : Shared types and helpers for the multi-cycle execute unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package exu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REM   = 4'd14,
        OP_REMU  = 4'd15
    } exu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } exu_state_e;

    localparam int unsigned c_xlen_default = 32;

    // Width of shift amounts and of the iteration counter for a given XLEN.
    function automatic int unsigned exu_log2(input int unsigned xlen);
        return $clog2(xlen);
    endfunction

    function automatic logic is_iter_op(input exu_op_e op);
        return (op inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

endpackage

`default_nettype wire

// File: rtl/exu_mc_mdu_iter.sv
// ============================================================================
// Module      : exu_mdu_iter
// Description : Iterative shift-add multiplier / restoring divider, one bit
//               per cycle, XLEN cycles per operation.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module exu_mdu_iter
    import exu_mc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  exu_op_e         op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     c_cw   = exu_log2(XLEN);
    localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);

    logic            r_busy;
    logic [c_cw-1:0] r_cnt;
    exu_op_e         r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_lo;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dz;
    logic [XLEN-1:0] r_src1;

    logic            w_sgn;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_acc_nxt;
    logic [XLEN-1:0] w_lo_nxt;

    assign w_sgn  = (op == OP_DIV) || (op == OP_REM);
    assign w_neg1 = w_sgn & src1[XLEN-1];
    assign w_neg2 = w_sgn & src2[XLEN-1];
    assign w_mag1 = w_neg1 ? (~src1 + 1'b1) : src1;
    assign w_mag2 = w_neg2 ? (~src2 + 1'b1) : src2;

    // acc:lo is the running product (mul) or remainder:quotient (div).
    assign w_div   = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign w_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_shift = {r_acc, r_lo[XLEN-1]};
    assign w_qbit  = (w_shift >= {1'b0, r_a});
    assign w_diff  = w_shift[XLEN-1:0] - r_a;

    always_comb begin
        if (w_div) begin
            w_acc_nxt = w_qbit ? w_diff : w_shift[XLEN-1:0];
            w_lo_nxt  = {r_lo[XLEN-2:0], w_qbit};
        end else begin
            w_acc_nxt = w_sum[XLEN:1];
            w_lo_nxt  = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign done = r_busy && (r_cnt == c_last);

    // Result is taken from the final step's next values, so it is valid with done.
    always_comb begin
        result = '0;
        case (r_op)
            OP_MUL:   result = w_lo_nxt;
            OP_MULHU: result = w_acc_nxt;
            OP_DIVU:  result = r_dz ? '1 : w_lo_nxt;
            OP_DIV:   result = r_dz ? '1 : (r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt);
            OP_REMU:  result = r_dz ? r_src1 : w_acc_nxt;
            OP_REM:   result = r_dz ? r_src1 : (r_neg_r ? (~w_acc_nxt + 1'b1) : w_acc_nxt);
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_a     <= '0;
            r_acc   <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_src1  <= '0;
        end else if (kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_op    <= op;
            r_acc   <= '0;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_dz    <= (src2 == '0);
            r_src1  <= src1;
            if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
                r_a  <= w_mag2;
                r_lo <= w_mag1;
            end else begin
                r_a  <= src1;
                r_lo <= src2;
            end
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_lo  <= w_lo_nxt;
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/exu_mc.sv
// ============================================================================
// Module      : exu_mc
// Description : Execute unit with single-cycle ALU and iterative mul/div,
//               valid/ready on both sides and flush support.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module exu_mc
    import exu_mc_pkg::*;
#(
    parameter int unsigned     XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  exu_op_e         op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            jump_flag,
    input  logic            reg_wen_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] reg_wdata,
    output logic            reg_wen,
    output logic [XLEN-1:0] dnpc
);

    localparam int unsigned c_shw = exu_log2(XLEN);

    exu_state_e      r_state;
    exu_state_e      w_state_nxt;
    logic            r_live;
    logic [XLEN-1:0] r_wdata;
    logic            r_wen;
    logic [XLEN-1:0] r_dnpc;

    logic            w_accept;
    logic            w_iter;
    logic            w_mdu_done;
    logic [XLEN-1:0] w_mdu_result;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_target;
    logic [c_shw-1:0] w_shamt;

    // r_live keeps in_ready low until the first edge after reset releases.
    assign in_ready  = (r_state == ST_IDLE) && !flush && r_live;
    assign out_valid = (r_state == ST_DONE);
    assign reg_wdata = r_wdata;
    assign reg_wen   = r_wen;
    assign dnpc      = r_dnpc;

    assign w_accept = in_valid && in_ready;
    assign w_iter   = is_iter_op(op) && !jump_flag;
    assign w_pc4    = pc + XLEN'(4);
    assign w_target = (src1 + src2) & ~XLEN'(1);
    assign w_shamt  = src2[c_shw-1:0];

    always_comb begin
        w_alu = '0;
        case (op)
            OP_ADD:  w_alu = src1 + src2;
            OP_SUB:  w_alu = src1 - src2;
            OP_AND:  w_alu = src1 & src2;
            OP_OR:   w_alu = src1 | src2;
            OP_XOR:  w_alu = src1 ^ src2;
            OP_SLL:  w_alu = src1 << w_shamt;
            OP_SRL:  w_alu = src1 >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(src1) >>> w_shamt);
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (src1 < src2)};
            default: w_alu = '0;
        endcase
    end

    exu_mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (w_accept && w_iter),
        .kill   (flush),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .done   (w_mdu_done),
        .result (w_mdu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_nxt = w_iter ? ST_CALC : ST_DONE;
                ST_CALC: if (w_mdu_done) w_state_nxt = ST_DONE;
                ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_dnpc  <= RST_PC;
        end else if (w_accept) begin
            r_wen  <= reg_wen_in;
            r_dnpc <= jump_flag ? w_target : w_pc4;
            if (!w_iter) begin
                r_wdata <= jump_flag ? w_pc4 : w_alu;
            end
        end else if ((r_state == ST_CALC) && w_mdu_done && !flush) begin
            r_wdata <= w_mdu_result;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exu_mc.sv
// ============================================================================
// Module      : tb_exu_mc
// Description : Scoreboard bench for exu_mc with a reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_exu_mc;
    import exu_mc_pkg::*;

    localparam logic [31:0] c_rst_pc = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    exu_op_e     op;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        jump_flag;
    logic        reg_wen_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [31:0] dnpc;

    exu_mc #(.XLEN(32), .RST_PC(c_rst_pc)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .pc         (pc),
        .src1       (src1),
        .src2       (src2),
        .jump_flag  (jump_flag),
        .reg_wen_in (reg_wen_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .reg_wdata  (reg_wdata),
        .reg_wen    (reg_wen),
        .dnpc       (dnpc)
    );

    typedef struct {
        logic [31:0] wdata;
        logic        wen;
        logic [31:0] dnpc;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   seen    = 0;
    bit   rnd_ready = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic logic [31:0] ref_op(input exu_op_e o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int signed   sa;
        int signed   sb_;
        sa  = a;
        sb_ = b;
        p   = {32'd0, a} * {32'd0, b};
        case (o)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_SLL:   return a << (b % 32);
            OP_SRL:   return a >> (b % 32);
            OP_SRA:   return sa >>> (b % 32);
            OP_SLT:   return (sa < sb_) ? 32'd1 : 32'd0;
            OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            OP_MUL:   return p[31:0];
            OP_MULHU: return p[63:32];
            OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:  return (b == 0) ? a : a % b;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb_;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb_;
            end
            default:  return 32'd0;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input exu_op_e o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic j, input logic w, input bit keep);
        exp_t e;
        int   n;
        in_valid = 1'b1; op = o; src1 = a; src2 = b; pc = p; jump_flag = j; reg_wen_in = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
        if (keep) begin
            e.wen     = w;
            e.acc_cyc = cyc;
            if (j) begin
                e.wdata = p + 32'd4;
                e.dnpc  = (a + b) & 32'hFFFF_FFFE;
                e.lat   = 1;
            end else begin
                e.wdata = ref_op(o, a, b);
                e.dnpc  = p + 32'd4;
                e.lat   = (o inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? 33 : 1;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1 = $urandom; src2 = $urandom; jump_flag = $urandom_range(0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || !in_ready) && n < 300);
        if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Random consumer backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every presented result is compared to the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got out_valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                if (!seen) begin
                    chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                    seen = 1;
                end
                chk("reg_wdata", 64'(reg_wdata), 64'(sb[0].wdata));
                chk("reg_wen", 64'(reg_wen), 64'(sb[0].wen));
                chk("dnpc", 64'(dnpc), 64'(sb[0].dnpc));
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; op = OP_ADD; pc = '0; src1 = '0; src2 = '0;
        jump_flag = 1'b0; reg_wen_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dnpc", 64'(dnpc), 64'(c_rst_pc));
        chk("rst_wdata", 64'(reg_wdata), 64'd0);
        chk("rst_wen", 64'(reg_wen), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(OP_ADD, 32'd5, 32'd7, 32'h0000_1000, 1'b0, 1'b1, 1);
        issue(OP_SUB, 32'd5, 32'd7, 32'h0000_1004, 1'b0, 1'b1, 1);
        issue(OP_ADD, 32'h8000_0100, 32'h5, 32'h8000_0010, 1'b1, 1'b1, 1);
        drain();

        // DIVU 100/7: in_ready must stay low through CALC and the held DONE cycle.
        rnd_ready = 0;
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 32'h100, 1'b0, 1'b1, 1);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            chk("divu_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rnd_ready = 1;
        drain();
        issue(OP_REMU, 32'd100, 32'd7, 32'h104, 1'b0, 1'b1, 1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h108, 1'b0, 1'b1, 1);
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h10C, 1'b0, 1'b1, 1);
        issue(OP_DIVU, 32'd1234, 32'd0, 32'h110, 1'b0, 1'b0, 1);
        issue(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'h114, 1'b0, 1'b1, 1);
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'h118, 1'b0, 1'b1, 1);
        drain();

        // MUL held under backpressure, then released.
        rnd_ready = 0;
        out_ready = 1'b0;
        issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h200, 1'b0, 1'b1, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
        rnd_ready = 1;
        @(posedge clk);
        #1;

        // Flush during MULHU: no result may ever appear.
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h300, 1'b0, 1'b1, 0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;

        // Reset in the middle of CALC.
        issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h400, 1'b0, 1'b1, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_dnpc", 64'(dnpc), 64'(c_rst_pc));
        chk("midrst_wdata", 64'(reg_wdata), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("first_edge_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            logic [31:0] p;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            p = $urandom & 32'hFFFF_FFFC;
            issue(exu_op_e'($urandom_range(0, 15)), rand_val(), rand_val(), p,
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
